bus_arbiter_rr: RTL
===================

# bus_arbiter_rr

Parametrised round-robin bus arbiter for N bus masters. It generalises the fixed 4-master arbiter with:
- a configurable master count;
- a per-master bus lock;
- an exported owner index;
- an optional tenure-limit (timeout) preemption that prevents one master from starving the others.

It sits between the master request lines and the bus master multiplexer, whose select input is `owner`.

## Interface
- `N_MASTERS`, default 4: number of masters; legal range 2..16.
- `OWNER_W`, default 2: owner index width; must equal ceil(log2(N_MASTERS)).
- `MAX_HOLD`, default 16: maximum consecutive owned cycles before preemption; legal range 2..256. Used only when `BUS_ARB_TIMEOUT_EN` is defined.
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: synchronous reset, active-high.
- `m_req_` in N_MASTERS: bus request per master, active-low.
- `m_lock_` in N_MASTERS: bus lock per master, active-low; honoured only for the current owner.
- `m_grnt_` out N_MASTERS: bus grant per master, active-low, one-hot-low.
- `owner` out OWNER_W: index of the current bus owner.
- `busy` out 1: active-high; asserted when the owner's request or lock is asserted.
- `preempt` out 1: active-high one-cycle pulse; asserted in the cycle after a timeout handover.

## Operation
- Single register `owner`.
  - `m_grnt_` is a combinational decode of `owner`.
  - Exactly one grant is low at all times, including while idle: the bus is always parked on the last owner.
- Hold condition: the owner O keeps the bus while `m_req_[O]==0` or `m_lock_[O]==0`.
- Release: when the hold condition is false, the next owner is the first requesting master in the order O+1, O+2, … N_MASTERS-1, 0, … O-1 (modulo N_MASTERS).
  - If no master requests, `owner` is unchanged (parking).
  - If only O itself would qualify after release, `owner` is also unchanged.
- Lock and request of non-owners are ignored for the hold decision; `m_lock_` of a non-owner has no effect.
- Tenure counter `hold_cnt`, width ceil(log2(MAX_HOLD))+1:
  - Clears on every owner change.
  - Otherwise increments while `busy` and saturates at MAX_HOLD-1.
  - Compiled in only with the macro.
- Timeout preemption:
  - Fires when all of the following hold: `hold_cnt==MAX_HOLD-1`, `m_req_[O]==0`, `m_lock_[O]==1` (lock wins over timeout), and at least one other master requests.
  - On firing, `owner` moves to the round-robin successor, searched excluding O.
  - `preempt` is 1 for the following cycle.
- `busy` is combinational from `owner`, `m_req_` and `m_lock_`.
- Non-power-of-two N_MASTERS: owner values ≥ N_MASTERS are unreachable. If one is ever present, the next clock forces `owner` to 0.

## Timing
- Reset (sampled at a rising edge with `reset==1`):
  - `owner`=0, `m_grnt_` = all ones except bit 0 = 0, `hold_cnt`=0, `preempt`=0.
  - `busy` follows the inputs for master 0.
- Reset mid-tenure aborts the tenure at that edge; arbitration resumes on the next edge.
- Arbitration latency: requests are sampled at edge t, and the new `owner`/`m_grnt_` are valid after edge t.
  - Handover takes exactly one clock after the owner deasserts its request and lock.
  - There are no dead cycles between owners.
- Simultaneous requests are resolved only by the round-robin order relative to the current owner.
- A request that is asserted and then withdrawn before the owner releases is never granted.
- Preemption occurs at the edge where the owner has been held for MAX_HOLD cycles counted from its grant, i.e. its MAX_HOLD-th owned cycle is the last.

## Configuration
- `BUS_ARB_TIMEOUT_EN` defined:
  - `hold_cnt` and the timeout preemption are present.
  - `preempt` is driven as specified.
- `BUS_ARB_TIMEOUT_EN` undefined:
  - No counter logic.
  - An owner keeps the bus indefinitely while requesting or locked.
  - `preempt` is tied to 0.
  - `MAX_HOLD` is ignored.

## Test plan
- Reset: assert `reset` for 2 cycles with all `m_req_`=1 → `owner`=0, `m_grnt_`=4'b1110, `busy`=0, `preempt`=0; state holds with no requests for 10 cycles.
- Round-robin, N_MASTERS=4:
  - Owner 1 releases while `m_req_`=4'b0110 (masters 0 and 3 requesting) → `owner`=3 next cycle.
  - Master 3 then releases → `owner`=0.
- Lock: owner 2 drops `m_req_[2]` but holds `m_lock_[2]`=0 for 5 cycles while master 0 requests → `owner` stays 2. Releasing the lock → `owner`=0 one cycle later.
- Timeout, macro on, MAX_HOLD=4:
  - Master 0 requests continuously, master 1 requests from the start → `owner`=1 after the 4th owned cycle, `preempt`=1 for one cycle.
  - Repeating with `m_lock_[0]`=0 → no preemption, `preempt`=0.
- Non-power-of-two, N_MASTERS=3, OWNER_W=2: owner 2 releases with only master 0 requesting → `owner`=0; `owner`=3 never observed over 1000 random request cycles.
- Mid-tenure reset: owner 3 is active with `hold_cnt`=2 and `reset` pulses for 1 cycle → `owner`=0 and `hold_cnt`=0 after that edge, normal arbitration on the next edge.

Source files
------------

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: round-robin bus arbiter for N_MASTERS masters with a per-master
// bus lock, an exported owner index and an optional tenure-limit preemption.
// Optional feature macro: BUS_ARB_TIMEOUT_EN (adds hold_cnt and the timeout
// handover; without it preempt is tied low and MAX_HOLD is unused).
// The bus is always parked on the last owner, so exactly one grant is low.

// Per-master slice: grant decode, request qualify and the owner hold term.
module bus_arb_lane #(
  parameter int IDX     = 0,
  parameter int OWNER_W = 2
) (
  input  logic [OWNER_W-1:0] owner,
  input  logic               req_n,
  input  logic               lock_n,
  output logic               grnt_n,
  output logic               want,
  output logic               hold
);
  logic is_owner;

  assign is_owner = (owner == OWNER_W'(IDX));
  assign grnt_n   = ~is_owner;
  assign want     = ~req_n;
  // Only the current owner's request/lock can keep the bus.
  assign hold     = is_owner & (~req_n | ~lock_n);
endmodule

module bus_arbiter_rr #(
  parameter int N_MASTERS = 4,
  parameter int OWNER_W   = 2,
  parameter int MAX_HOLD  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_MASTERS-1:0] m_req_,
  input  logic [N_MASTERS-1:0] m_lock_,
  output logic [N_MASTERS-1:0] m_grnt_,
  output logic [OWNER_W-1:0]   owner,
  output logic                 busy,
  output logic                 preempt
);
  // Elaboration-time parameter sanity checks.
  if (N_MASTERS < 2 || N_MASTERS > 16) begin : g_bad_n
    $error("bus_arbiter_rr: N_MASTERS must be 2..16");
  end
  if (OWNER_W != $clog2(N_MASTERS)) begin : g_bad_w
    $error("bus_arbiter_rr: OWNER_W must equal clog2(N_MASTERS)");
  end
  if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_hold
    $error("bus_arbiter_rr: MAX_HOLD must be 2..256");
  end

  logic [N_MASTERS-1:0] want;
  logic [N_MASTERS-1:0] hold_vec;
  logic                 own_hold;
  logic                 owner_ok;
  logic                 rr_found;
  logic [OWNER_W-1:0]   rr_next;
  logic [OWNER_W:0]     rr_idx;
  logic [OWNER_W-1:0]   next_owner;

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_lane
    bus_arb_lane #(.IDX(i), .OWNER_W(OWNER_W)) u_lane (
      .owner  (owner),
      .req_n  (m_req_[i]),
      .lock_n (m_lock_[i]),
      .grnt_n (m_grnt_[i]),
      .want   (want[i]),
      .hold   (hold_vec[i])
    );
  end

  assign own_hold = |hold_vec;
  assign busy     = own_hold;

  // Out-of-range owner codes only exist when N_MASTERS is not a power of two.
  if ((1 << OWNER_W) > N_MASTERS) begin : g_np2
    assign owner_ok = ({1'b0, owner} < (OWNER_W+1)'(N_MASTERS));
  end else begin : g_p2
    assign owner_ok = 1'b1;
  end

  // Round-robin successor search starting at owner+1, never selecting owner;
  // the loop runs from the farthest distance down so the nearest requester wins.
  always_comb begin
    rr_found = 1'b0;
    rr_next  = owner;
    rr_idx   = '0;
    for (int k = N_MASTERS-1; k >= 1; k--) begin
      rr_idx = {1'b0, owner} + (OWNER_W+1)'(k);
      if (rr_idx >= (OWNER_W+1)'(N_MASTERS))
        rr_idx = rr_idx - (OWNER_W+1)'(N_MASTERS);
      if (want[rr_idx[OWNER_W-1:0]]) begin
        rr_found = 1'b1;
        rr_next  = rr_idx[OWNER_W-1:0];
      end
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int HC_W = $clog2(MAX_HOLD) + 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

  logic [HC_W-1:0] hold_cnt;
  logic            own_req;
  logic            own_lock;
  logic            fire;

  assign own_req  = |(~m_grnt_ & ~m_req_);
  assign own_lock = |(~m_grnt_ & ~m_lock_);

  // Next owner: recover from illegal codes, hand over on release, or preempt
  // a requesting but unlocked owner whose tenure has run out.
  always_comb begin
    next_owner = owner;
    fire       = 1'b0;
    if (!owner_ok) begin
      next_owner = '0;
    end else if (!own_hold) begin
      if (rr_found) next_owner = rr_next;
    end else if (hold_cnt == HOLD_LAST && own_req && !own_lock && rr_found) begin
      next_owner = rr_next;
      fire       = 1'b1;
    end
  end

  // Tenure counter: restarts on every handover, saturates at the limit.
  always_ff @(posedge clk) begin
    if (reset)                                hold_cnt <= '0;
    else if (next_owner != owner)             hold_cnt <= '0;
    else if (busy && hold_cnt != HOLD_LAST)   hold_cnt <= hold_cnt + HC_W'(1);
  end

  // Preempt pulse marks the first cycle of the new owner after a timeout.
  always_ff @(posedge clk) begin
    if (reset) preempt <= 1'b0;
    else       preempt <= fire;
  end
`else
  // Next owner: recover from illegal codes, otherwise hand over on release.
  always_comb begin
    next_owner = owner;
    if (!owner_ok) begin
      next_owner = '0;
    end else if (!own_hold) begin
      if (rr_found) next_owner = rr_next;
    end
  end

  assign preempt = 1'b0;
`endif

  // Owner register; reset parks the bus on master 0.
  always_ff @(posedge clk) begin
    if (reset) owner <= '0;
    else       owner <= next_owner;
  end
endmodule
